// File: rtl/rtx_pkg.sv
// Shared types for the ray-tracing front end: pixel coordinate widths and
// the pixel scheduler state encoding.
package rtx_pkg;

    typedef logic [10:0] pixel_h_t;
    typedef logic [9:0]  pixel_v_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_e;

endpackage

// File: rtl/pixel_order_gen.sv
// Pixel walk generator: holds the current pixel coordinate and steps it to the
// next pixel of the frame on each advance.
// Build option PIXEL_SCHED_TILED_EN: when defined, pixels are visited in
// TILE x TILE tiles (raster inside a tile, tiles in raster order); otherwise
// plain raster order across the whole frame.
module pixel_order_gen
    import rtx_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720,
    parameter int TILE   = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     advance,
    input  logic     clear,
    output pixel_h_t h,
    output pixel_v_t v,
    output logic     last
);

    // Both orders are one walker: raster is the degenerate tiling where a tile
    // spans a full row and is one line high, so TILE has no influence there.
`ifdef PIXEL_SCHED_TILED_EN
    localparam int TILE_W = TILE;
    localparam int TILE_H = TILE;
`else
    localparam int TILE_W = WIDTH + 0 * TILE;
    localparam int TILE_H = 1;
`endif

    localparam pixel_h_t H_LAST      = pixel_h_t'(WIDTH - 1);
    localparam pixel_v_t V_LAST      = pixel_v_t'(HEIGHT - 1);
    localparam pixel_h_t TW          = pixel_h_t'(TILE_W);
    localparam pixel_v_t TH          = pixel_v_t'(TILE_H);
    localparam pixel_h_t TW_M1       = pixel_h_t'(TILE_W - 1);
    localparam pixel_v_t TH_M1       = pixel_v_t'(TILE_H - 1);
    localparam pixel_h_t H_LAST_BASE = pixel_h_t'(WIDTH - TILE_W);
    localparam pixel_v_t V_LAST_BASE = pixel_v_t'(HEIGHT - TILE_H);

    pixel_h_t h_q, h_d, th_q, th_d;
    pixel_v_t v_q, v_d, tv_q, tv_d;

    // Next-pixel stepping: finish the tile row, then the tile, then move to the next tile.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        th_d = th_q;
        tv_d = tv_q;
        if (clear) begin
            h_d  = '0;
            v_d  = '0;
            th_d = '0;
            tv_d = '0;
        end else if (advance) begin
            if (h_q != th_q + TW_M1) begin
                h_d = h_q + pixel_h_t'(1);
            end else if (v_q != tv_q + TH_M1) begin
                h_d = th_q;
                v_d = v_q + pixel_v_t'(1);
            end else if (th_q != H_LAST_BASE) begin
                th_d = th_q + TW;
                h_d  = th_q + TW;
                v_d  = tv_q;
            end else begin
                th_d = '0;
                h_d  = '0;
                tv_d = (tv_q == V_LAST_BASE) ? '0 : tv_q + TH;
                v_d  = tv_d;
            end
        end
    end

    // Coordinate and tile-origin registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q  <= '0;
            v_q  <= '0;
            th_q <= '0;
            tv_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            th_q <= th_d;
            tv_q <= tv_d;
        end
    end

    assign h    = h_q;
    assign v    = v_q;
    assign last = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/pixel_scheduler.sv
// Pixel scheduler: issues one ray request per frame pixel, throttled by an
// in-flight credit counter, and reports frame completion once every issued
// ray has retired. Pixel order comes from pixel_order_gen; build option
// PIXEL_SCHED_TILED_EN selects tiled instead of raster order.
module pixel_scheduler
    import rtx_pkg::*;
#(
    parameter int WIDTH         = 1280,
    parameter int HEIGHT        = 720,
    parameter int MAX_IN_FLIGHT = 16,
    parameter int TILE          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ray_ready,
    input  logic        ray_retire,
    output logic [10:0] pixel_h,
    output logic [9:0]  pixel_v,
    output logic        new_ray,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        retire_err
);

    localparam int            CW         = $clog2(MAX_IN_FLIGHT + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_IN_FLIGHT);

    sched_state_e  state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    pixel_h_t      pixel_h_q, pixel_h_d;
    pixel_v_t      pixel_v_q, pixel_v_d;
    logic          new_ray_q, new_ray_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          retire_err_q, retire_err_d;

    logic          issue;
    pixel_h_t      gen_h;
    pixel_v_t      gen_v;
    logic          gen_last;

    assign issue = (state_q == ISSUE) && ray_ready && (credit_q < CREDIT_MAX);

    // The walker is held at the first pixel while idle so every frame starts at the origin.
    pixel_order_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .TILE   (TILE)
    ) u_order (
        .clk     (clk),
        .rst     (rst),
        .advance (issue),
        .clear   (state_q == IDLE),
        .h       (gen_h),
        .v       (gen_v),
        .last    (gen_last)
    );

    // Credit bookkeeping: issue and retire together cancel; a retire with nothing in flight is flagged.
    always_comb begin
        credit_d     = credit_q;
        retire_err_d = retire_err_q;
        if (issue && !ray_retire) begin
            credit_d = credit_q + CW'(1);
        end else if (!issue && ray_retire) begin
            if (credit_q == '0) begin
                retire_err_d = 1'b1;
            end else begin
                credit_d = credit_q - CW'(1);
            end
        end
    end

    // Frame sequencing; drain is skipped when the last issue already leaves nothing in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (issue && gen_last) state_d = (credit_d == '0) ? DONE : DRAIN;
            DRAIN:   if (credit_d == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered ray request and frame counter updates.
    always_comb begin
        new_ray_d     = issue;
        pixel_h_d     = issue ? gen_h : pixel_h_q;
        pixel_v_d     = issue ? gen_v : pixel_v_q;
        frame_count_d = (state_q == DONE) ? frame_count_q + 16'd1 : frame_count_q;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            pixel_h_q     <= '0;
            pixel_v_q     <= '0;
            new_ray_q     <= 1'b0;
            frame_count_q <= '0;
            retire_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            pixel_h_q     <= pixel_h_d;
            pixel_v_q     <= pixel_v_d;
            new_ray_q     <= new_ray_d;
            frame_count_q <= frame_count_d;
            retire_err_q  <= retire_err_d;
        end
    end

    assign pixel_h     = pixel_h_q;
    assign pixel_v     = pixel_v_q;
    assign new_ray     = new_ray_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = (state_q == DONE);
    assign frame_count = frame_count_q;
    assign retire_err  = retire_err_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Testbench for pixel_scheduler: directed frames plus randomized ready/retire
// traffic, compared every cycle against a frame-level reference model.
module tb_pixel_scheduler;

`ifdef PIXEL_SCHED_TILED_EN
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int T  = 8;
    localparam int TW = T;
    localparam int TH = T;
`else
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int T  = 8;
    localparam int TW = W;
    localparam int TH = 1;
`endif
    localparam int MAXF = 2;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ray_ready;
    logic        ray_retire;
    logic [10:0] pixel_h;
    logic [9:0]  pixel_v;
    logic        new_ray;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        retire_err;

    pixel_scheduler #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .MAX_IN_FLIGHT (MAXF),
        .TILE          (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ray_ready   (ray_ready),
        .ray_retire  (ray_retire),
        .pixel_h     (pixel_h),
        .pixel_v     (pixel_v),
        .new_ray     (new_ray),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .retire_err  (retire_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected visiting order, built from the tiling rule
    int order_h[NPIX];
    int order_v[NPIX];

    // Reference model: phase 0 idle, 1 frame running, 2 frame-done pulse
    int m_phase, m_n, m_inf, m_fc, m_h, m_v;
    bit m_err, m_new;

    // Observation helpers
    int obs_rays;
    bit seen[NPIX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_phase = 0; m_n = 0; m_inf = 0; m_fc = 0;
        m_h = 0; m_v = 0; m_err = 0; m_new = 0;
    endtask

    task automatic modelStep();
        int  old_phase;
        bit  iss;
        old_phase = m_phase;
        m_new = 0;
        iss = (old_phase == 1) && (m_n < NPIX) && ray_ready && (m_inf < MAXF);
        if (old_phase == 0 && start) begin
            m_phase = 1;
            m_n = 0;
        end else if (old_phase == 2) begin
            m_phase = 0;
            m_fc = (m_fc + 1) % 65536;
        end
        if (iss) begin
            m_h = order_h[m_n];
            m_v = order_v[m_n];
            m_n++;
            m_new = 1;
        end
        if (iss && ray_retire) begin
        end else if (iss) begin
            m_inf++;
        end else if (ray_retire) begin
            if (m_inf == 0) m_err = 1;
            else m_inf--;
        end
        if (old_phase == 1 && m_n == NPIX && m_inf == 0) m_phase = 2;
    endtask

    task automatic checkOutput();
        check("new_ray", new_ray, m_new);
        check("pixel_h", pixel_h, m_h);
        check("pixel_v", pixel_v, m_v);
        check("busy", busy, m_phase != 0);
        check("frame_done", frame_done, m_phase == 2);
        check("frame_count", frame_count, m_fc);
        check("retire_err", retire_err, m_err);
        if (new_ray === 1'b1) begin
            obs_rays++;
            if (pixel_h < W && pixel_v < H) seen[pixel_v * W + pixel_h] = 1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic t);
        start      = s;
        ray_ready  = r;
        ray_retire = t;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    // Runs the current frame to completion with retires whenever rays are outstanding
    task automatic finishFrame(input string tag);
        for (int i = 0; i < 400 && m_phase != 0; i++)
            applyStimulus(1'b0, 1'b1, m_inf > 0);
        check(tag, busy, 1'b0);
    endtask

    initial begin
        int idx;
        int uniq;
        idx = 0;
        for (int ty = 0; ty < H; ty += TH)
            for (int tx = 0; tx < W; tx += TW)
                for (int y = 0; y < TH; y++)
                    for (int x = 0; x < TW; x++) begin
                        order_h[idx] = tx + x;
                        order_v[idx] = ty + y;
                        idx++;
                    end

        rst = 1'b1; start = 1'b0; ray_ready = 1'b0; ray_retire = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        rst = 1'b0;
        $display("[TB] reset checked");

        // Frame A: always ready, each ray retired the cycle after it appears
        obs_rays = 0;
        for (int i = 0; i < NPIX; i++) seen[i] = 0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        check("first_latency_a", new_ray, 1'b0);
        for (int i = 0; i < 400 && m_phase != 0; i++)
            applyStimulus(1'b0, 1'b1, m_new);
        check("frameA_idle", busy, 1'b0);
        check("frameA_count", frame_count, 16'd1);
        check("frameA_rays", obs_rays, NPIX);
        uniq = 0;
        for (int i = 0; i < NPIX; i++) uniq += seen[i];
        check("frameA_unique", uniq, NPIX);

        // Frame B: credit stall, single retire, ignored restart, toggling ready
        obs_rays = 0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
        check("stall_rays", obs_rays, MAXF);
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        check("one_more_ray", obs_rays, MAXF + 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 400 && m_phase != 0; i++)
            applyStimulus(1'b0, i[0], (m_inf > 0) && (i % 3 == 0));
        finishFrame("frameB_idle");
        check("frameB_count", frame_count, 16'd2);

        // Randomized traffic with occasional starts
        for (int i = 0; i < 800; i++)
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                          (m_inf > 0) && ($urandom_range(0, 1) == 1));
        finishFrame("random_idle");

        // Retire with nothing in flight
        applyStimulus(1'b0, 1'b0, 1'b1);
        check("retire_err_set", retire_err, 1'b1);

        // Reset in the middle of a frame, late retire, then a fresh frame
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 modelReset();
        checkOutput();
        check("async_busy", busy, 1'b0);
        check("async_count", frame_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        check("late_retire_err", retire_err, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        check("restart_new_ray", new_ray, 1'b1);
        check("restart_h", pixel_h, 11'd0);
        check("restart_v", pixel_v, 10'd0);
        finishFrame("final_idle");
        check("final_count", frame_count, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
